// File: rtl/gpio_pkg.sv
// Shared types and width helpers for the gpio host-side handshake port.
package gpio_pkg;

  localparam int unsigned PORT_NUM_DEF = 8;
  localparam int unsigned CONF0_W      = 3 * PORT_NUM_DEF;
  localparam int unsigned CONF1_W      = 2 * PORT_NUM_DEF + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL
  } hs_state_t;

  function automatic int unsigned conf0_w(input int unsigned port_num);
    return 3 * port_num;
  endfunction

  function automatic int unsigned conf1_w(input int unsigned port_num);
    return 2 * port_num + 1;
  endfunction

endpackage

// File: rtl/gpio_hs_master.sv
// 4-phase handshake initiator: accepts a word on valid/ready and drives req until acked.
module gpio_hs_master
  import gpio_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  input  logic          ack_hi_i,
  input  logic          ack_lo_i
);

  hs_state_t     state_q;
  logic          ready_q;
  logic          req_q;
  logic [DW-1:0] data_q;

  // ready is registered, so it reads 0 for one cycle after reset releases
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (valid_i && ready_q) begin
            data_q  <= data_i;
            req_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_hi_i) begin
            req_q   <= 1'b0;
            state_q <= REL;
          end
        end
        REL: begin
          if (ack_lo_i) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign req_o   = req_q;
  assign data_o  = data_q;

endmodule

// File: rtl/gpio_hs_sync.sv
// Multi-stage flop synchronizer for incoming 4-phase req/ack levels.
module gpio_hs_sync #(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] chain_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      chain_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gpio_host_port.sv
// Synchronous host-side counterpart of gpio_top's asynchronous 4-phase ports.
module gpio_host_port
  import gpio_pkg::*;
#(
  parameter int unsigned PORT_NUM   = PORT_NUM_DEF,
  parameter int unsigned SYNC_STAGE = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [PORT_NUM-1:0]   wr_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3*PORT_NUM-1:0] cfg_0,
  input  logic [2*PORT_NUM:0]   cfg_1,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [PORT_NUM-1:0]   rd_data,
  output logic [PORT_NUM:0]     irq_pending,
  input  logic [PORT_NUM:0]     irq_clear,
  output logic                  async_din_req,
  input  logic                  async_din_ack,
  output logic [PORT_NUM-1:0]   async_din,
  input  logic                  async_dout_req,
  output logic                  async_dout_ack,
  input  logic [PORT_NUM-1:0]   async_dout,
  input  logic [PORT_NUM:0]     async_ir_req,
  output logic [PORT_NUM:0]     async_ir_ack,
  output logic                  async_conf_0_req,
  input  logic                  async_conf_0_ack,
  output logic [3*PORT_NUM-1:0] async_conf_0,
  output logic                  async_conf_1_req,
  input  logic                  async_conf_1_ack,
  output logic [2*PORT_NUM:0]   async_conf_1
);

  localparam int unsigned C0W = conf0_w(PORT_NUM);
  localparam int unsigned C1W = conf1_w(PORT_NUM);
  localparam int unsigned CW  = C0W + C1W;

  logic                din_ack_s;
  logic                conf0_ack_s;
  logic                conf1_ack_s;
  logic                dout_req_s;
  logic [PORT_NUM:0]   ir_req_s;

  logic                conf_req;
  logic [CW-1:0]       conf_data;

  logic                rd_valid_q;
  logic [PORT_NUM-1:0] rd_data_q;
  logic                dout_ack_q;

  logic [PORT_NUM:0]   ir_ack_q;
  logic [PORT_NUM:0]   ir_ack_d;
  logic [PORT_NUM:0]   irq_pend_q;
  logic [PORT_NUM:0]   irq_pend_d;
  logic [PORT_NUM:0]   ir_set;
  logic [PORT_NUM:0]   ir_rel;

  gpio_hs_sync #(.W(1), .STAGES(SYNC_STAGE)) u_sync_din_ack (
    .clk_i(clock), .rst_i(reset), .d_i(async_din_ack), .q_o(din_ack_s)
  );

  gpio_hs_sync #(.W(1), .STAGES(SYNC_STAGE)) u_sync_conf0_ack (
    .clk_i(clock), .rst_i(reset), .d_i(async_conf_0_ack), .q_o(conf0_ack_s)
  );

  gpio_hs_sync #(.W(1), .STAGES(SYNC_STAGE)) u_sync_conf1_ack (
    .clk_i(clock), .rst_i(reset), .d_i(async_conf_1_ack), .q_o(conf1_ack_s)
  );

  gpio_hs_sync #(.W(1), .STAGES(SYNC_STAGE)) u_sync_dout_req (
    .clk_i(clock), .rst_i(reset), .d_i(async_dout_req), .q_o(dout_req_s)
  );

  gpio_hs_sync #(.W(PORT_NUM + 1), .STAGES(SYNC_STAGE)) u_sync_ir_req (
    .clk_i(clock), .rst_i(reset), .d_i(async_ir_req), .q_o(ir_req_s)
  );

  gpio_hs_master #(.DW(PORT_NUM)) u_din_master (
    .clk_i    (clock),
    .rst_i    (reset),
    .valid_i  (wr_valid),
    .ready_o  (wr_ready),
    .data_i   (wr_data),
    .req_o    (async_din_req),
    .data_o   (async_din),
    .ack_hi_i (din_ack_s),
    .ack_lo_i (!din_ack_s)
  );

  // Both conf words travel as one transaction: release waits for both acks high, idle for both low
  gpio_hs_master #(.DW(CW)) u_conf_master (
    .clk_i    (clock),
    .rst_i    (reset),
    .valid_i  (cfg_valid),
    .ready_o  (cfg_ready),
    .data_i   ({cfg_0, cfg_1}),
    .req_o    (conf_req),
    .data_o   (conf_data),
    .ack_hi_i (conf0_ack_s && conf1_ack_s),
    .ack_lo_i (!conf0_ack_s && !conf1_ack_s)
  );

  assign async_conf_0_req = conf_req;
  assign async_conf_1_req = conf_req;
  assign async_conf_0     = conf_data[CW-1:C1W];
  assign async_conf_1     = conf_data[C1W-1:0];

  // Ack is withheld while the read buffer is full, which stalls the remote sender
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      dout_ack_q <= 1'b0;
    end else begin
      if (dout_req_s && !dout_ack_q && !rd_valid_q) begin
        rd_data_q  <= async_dout;
        rd_valid_q <= 1'b1;
        dout_ack_q <= 1'b1;
      end else begin
        if (rd_valid_q && rd_ready) begin
          rd_valid_q <= 1'b0;
        end
        if (!dout_req_s && dout_ack_q) begin
          dout_ack_q <= 1'b0;
        end
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign async_dout_ack = dout_ack_q;

  always_comb begin
    ir_set     = ir_req_s & ~ir_ack_q;
    ir_rel     = ~ir_req_s & ir_ack_q;
    ir_ack_d   = (ir_ack_q | ir_set) & ~ir_rel;
    irq_pend_d = (irq_pend_q & ~irq_clear) | ir_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_ack_q   <= '0;
      irq_pend_q <= '0;
    end else begin
      ir_ack_q   <= ir_ack_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign async_ir_ack = ir_ack_q;
  assign irq_pending  = irq_pend_q;

endmodule

// File: tb/tb_gpio_host_port.sv
// Directed bench for gpio_host_port acting as the remote gpio_top side.
module tb_gpio_host_port;
  import gpio_pkg::*;

  localparam int unsigned PN = 8;

  logic          clock;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [PN-1:0] wr_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CONF0_W-1:0] cfg_0;
  logic [CONF1_W-1:0] cfg_1;
  logic          rd_valid;
  logic          rd_ready;
  logic [PN-1:0] rd_data;
  logic [PN:0]   irq_pending;
  logic [PN:0]   irq_clear;
  logic          async_din_req;
  logic          async_din_ack;
  logic [PN-1:0] async_din;
  logic          async_dout_req;
  logic          async_dout_ack;
  logic [PN-1:0] async_dout;
  logic [PN:0]   async_ir_req;
  logic [PN:0]   async_ir_ack;
  logic          async_conf_0_req;
  logic          async_conf_0_ack;
  logic [CONF0_W-1:0] async_conf_0;
  logic          async_conf_1_req;
  logic          async_conf_1_ack;
  logic [CONF1_W-1:0] async_conf_1;

  int total;
  int bad;
  logic [127:0] sb[$];

  gpio_host_port #(.PORT_NUM(PN), .SYNC_STAGE(2)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_0(cfg_0), .cfg_1(cfg_1),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .irq_pending(irq_pending), .irq_clear(irq_clear),
    .async_din_req(async_din_req), .async_din_ack(async_din_ack), .async_din(async_din),
    .async_dout_req(async_dout_req), .async_dout_ack(async_dout_ack), .async_dout(async_dout),
    .async_ir_req(async_ir_req), .async_ir_ack(async_ir_ack),
    .async_conf_0_req(async_conf_0_req), .async_conf_0_ack(async_conf_0_ack),
    .async_conf_0(async_conf_0),
    .async_conf_1_req(async_conf_1_req), .async_conf_1_ack(async_conf_1_ack),
    .async_conf_1(async_conf_1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [127:0] obs);
    logic [127:0] e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s: observed %0h expected nothing (scoreboard empty)", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({wr_ready, cfg_ready, rd_valid, rd_data, irq_pending,
                 async_din_req, async_din, async_dout_ack, async_ir_ack,
                 async_conf_0_req, async_conf_0, async_conf_1_req, async_conf_1});
  endfunction

  initial begin
    int n;
    int pops;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    wr_valid = 1'b0; wr_data = '0;
    cfg_valid = 1'b0; cfg_0 = '0; cfg_1 = '0;
    rd_ready = 1'b0; irq_clear = '0;
    async_din_ack = 1'b0; async_dout_req = 1'b0; async_dout = '0;
    async_ir_req = '0; async_conf_0_ack = 1'b0; async_conf_1_ack = 1'b0;

    // reset state
    step(3);
    chk_eq("rst_outs", all_outs(), 128'(0));
    reset = 1'b0;
    step(1);
    chk_eq("rst_ready", 128'({wr_ready, cfg_ready}), 128'(2'b11));

    // din write, remote acks 3 cycles after req
    wr_valid = 1'b1; wr_data = 8'hA5;
    sb.push_back(128'(8'hA5));
    step(1);
    wr_valid = 1'b0; wr_data = 8'h00;
    sb_chk("din_data", 128'(async_din));
    chk_eq("din_req_ready", 128'({async_din_req, wr_ready}), 128'(2'b10));
    step(2);
    chk_eq("din_hold", 128'({async_din_req, async_din}), 128'({1'b1, 8'hA5}));
    async_din_ack = 1'b1;
    n = 0;
    do begin step(1); n++; end while (async_din_req && n < 20);
    chk_eq("din_req_fall_edges", 128'(n), 128'(3));
    chk_eq("din_rel_data", 128'({wr_ready, async_din}), 128'({1'b0, 8'hA5}));
    async_din_ack = 1'b0;
    n = 0;
    do begin step(1); n++; end while (!wr_ready && n < 20);
    chk_eq("din_ready_edges", 128'(n), 128'(3));
    step(4);
    chk_eq("din_single", 128'({async_din_req, async_din}), 128'({1'b0, 8'hA5}));

    // conf write, conf_1 ack lags conf_0 ack by 4 cycles
    cfg_valid = 1'b1; cfg_0 = 24'h003CF0; cfg_1 = 17'h0AAAA;
    sb.push_back(128'({24'h003CF0, 17'h0AAAA}));
    step(1);
    cfg_valid = 1'b0; cfg_0 = '0; cfg_1 = '0;
    sb_chk("conf_data", 128'({async_conf_0, async_conf_1}));
    chk_eq("conf_reqs", 128'({async_conf_0_req, async_conf_1_req, cfg_ready}), 128'(3'b110));
    async_conf_0_ack = 1'b1;
    step(4);
    chk_eq("conf_hold_one_ack", 128'({async_conf_0_req, async_conf_1_req}), 128'(2'b11));
    async_conf_1_ack = 1'b1;
    n = 0;
    do begin step(1); n++; end while (async_conf_0_req && n < 20);
    chk_eq("conf_req_fall_edges", 128'(n), 128'(3));
    async_conf_0_ack = 1'b0;
    step(4);
    chk_eq("conf_rel_one_ack", 128'({cfg_ready, async_conf_1_req}), 128'(2'b00));
    async_conf_1_ack = 1'b0;
    n = 0;
    do begin step(1); n++; end while (!cfg_ready && n < 20);
    chk_eq("conf_ready_edges", 128'(n), 128'(3));

    // dout with backpressure
    async_dout = 8'h3C; async_dout_req = 1'b1;
    sb.push_back(128'(8'h3C));
    n = 0;
    do begin step(1); n++; end while (!async_dout_ack && n < 20);
    chk_eq("dout_ack_edges", 128'(n), 128'(3));
    chk_eq("dout_valid", 128'(rd_valid), 128'(1));
    async_dout_req = 1'b0;
    n = 0;
    do begin step(1); n++; end while (async_dout_ack && n < 20);
    chk_eq("dout_ack_fall_edges", 128'(n), 128'(3));
    async_dout = 8'hC3; async_dout_req = 1'b1;
    sb.push_back(128'(8'hC3));
    step(8);
    chk_eq("dout_withheld", 128'({async_dout_ack, rd_valid}), 128'(2'b01));
    rd_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      if (rd_valid) begin
        sb_chk("dout_pop", 128'(rd_data));
        pops++;
      end
      step(1);
    end
    chk_eq("dout_pop_count", 128'(pops), 128'(2));
    chk_eq("dout_sb_empty", 128'(sb.size()), 128'(0));
    async_dout_req = 1'b0;
    rd_ready = 1'b0;
    n = 0;
    do begin step(1); n++; end while (async_dout_ack && n < 20);
    chk_eq("dout2_ack_fall_edges", 128'(n), 128'(3));

    // ir on bits 0 and 8
    async_ir_req = 9'h101;
    n = 0;
    do begin step(1); n++; end while (async_ir_ack != 9'h101 && n < 20);
    chk_eq("ir_ack_edges", 128'(n), 128'(3));
    chk_eq("ir_pending", 128'(irq_pending), 128'(9'h101));
    async_ir_req = '0;
    n = 0;
    do begin step(1); n++; end while (async_ir_ack != 9'h000 && n < 20);
    chk_eq("ir_ack_fall_edges", 128'(n), 128'(3));
    chk_eq("ir_pending_sticky", 128'(irq_pending), 128'(9'h101));
    irq_clear = 9'h100;
    step(1);
    irq_clear = '0;
    chk_eq("ir_clear_bit8", 128'(irq_pending), 128'(9'h001));
    irq_clear = 9'h1FF;
    step(1);
    irq_clear = '0;
    chk_eq("ir_clear_all", 128'(irq_pending), 128'(9'h000));
    async_ir_req = 9'h001;
    step(2);
    irq_clear = 9'h001;
    step(1);
    irq_clear = '0;
    chk_eq("ir_set_beats_clear", 128'({async_ir_ack, irq_pending}), 128'({9'h001, 9'h001}));
    async_ir_req = '0;
    n = 0;
    do begin step(1); n++; end while (async_ir_ack != 9'h000 && n < 20);
    chk_eq("ir2_ack_fall_edges", 128'(n), 128'(3));

    // reset while din is mid-REQ
    wr_valid = 1'b1; wr_data = 8'h5A;
    step(1);
    wr_valid = 1'b0;
    chk_eq("mid_req", 128'({async_din_req, async_din}), 128'({1'b1, 8'h5A}));
    reset = 1'b1;
    step(1);
    chk_eq("mid_rst_outs", all_outs(), 128'(0));
    step(4);
    reset = 1'b0;
    step(1);
    chk_eq("mid_rst_release", 128'({wr_ready, cfg_ready, async_din_req}), 128'(3'b110));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_host_port.md
# gpio_host_port

Synchronous host-side counterpart of `gpio_top`'s asynchronous 4-phase ports. It initiates the `din` and `conf_0`/`conf_1` handshakes and responds to the `dout` and `ir` handshakes. It presents simple valid/ready and pending-bit interfaces to logic in its own clock domain, and its `async_*` ports connect pin-for-pin to `gpio_top`.

## Interface
Parameters:
- `PORT_NUM`, 8: GPIO width.
- `SYNC_STAGE`, 2: flop stages on every incoming async req/ack.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in PORT_NUM: output-data write.
- `cfg_valid` in 1, `cfg_ready` out 1: configuration write.
- `cfg_0` in 3*PORT_NUM: configuration word 0.
- `cfg_1` in 2*PORT_NUM+1: configuration word 1.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out PORT_NUM: sampled input data.
- `irq_pending` out PORT_NUM+1: sticky interrupt flags.
- `irq_clear` in PORT_NUM+1: write-one-to-clear.
- `async_din_req` out 1, `async_din_ack` in 1, `async_din` out PORT_NUM.
- `async_dout_req` in 1, `async_dout_ack` out 1, `async_dout` in PORT_NUM.
- `async_ir_req` in PORT_NUM+1, `async_ir_ack` out PORT_NUM+1.
- `async_conf_0_req` out 1, `async_conf_0_ack` in 1, `async_conf_0` out 3*PORT_NUM.
- `async_conf_1_req` out 1, `async_conf_1_ack` in 1, `async_conf_1` out 2*PORT_NUM+1.

## Operation
- All incoming `async_*_req` and `async_*_ack` bits pass through a SYNC_STAGE synchronizer before use. Async data buses are never synchronized; they are sampled only after the synchronized req is seen.
- **Master FSM** (`din`; also `conf` with both reqs driven together) has states IDLE, REQ, REL:
  - IDLE: `*_ready`=1. On valid, register the data, set req=1, go to REQ.
  - REQ: hold req=1 with data stable. When the synchronized ack (for conf: both acks) is 1, set req=0 and go to REL.
  - REL: when the synchronized ack (for conf: both acks) is 0, go to IDLE.
  - Data on `async_din`/`async_conf_*` is held from acceptance until the next acceptance.
- **dout responder**:
  - If sync req=1, ack=0 and the read buffer is empty: capture `async_dout` into `rd_data`, set `rd_valid`=1 and `async_dout_ack`=1.
  - If sync req=0 and ack=1: set ack=0.
  - While the buffer is full, ack stays 0. This backpressures `gpio_top`.
  - The buffer empties on `rd_valid & rd_ready`.
- **ir responder**, per bit i:
  - Sync req=1, ack=0: set ack=1 and set `irq_pending[i]`.
  - Sync req=0, ack=1: set ack=0.
  - `irq_clear[i]`=1 clears the pending bit. If set and clear occur in the same cycle, set wins.
- Reset forces every output to 0 in the same cycle, whatever the state: all reqs/acks, `rd_valid`, `irq_pending`, data registers, and synchronizer flops. Both FSMs return to IDLE and `*_ready` reads 1 after reset releases.

## Timing
- Valid accepted at edge N: `async_*_req`=1 after edge N. `*_ready`=0 from edge N until the FSM re-enters IDLE.
- A remote ack edge is seen SYNC_STAGE cycles after it changes.
- Minimum master transaction with zero-delay remote: 2·SYNC_STAGE+2 cycles from acceptance to `*_ready` high.
- dout: `rd_valid` and ack rise SYNC_STAGE+1 edges after `async_dout_req` rises with the buffer empty.
- ir: `irq_pending` and ack rise SYNC_STAGE+1 edges after req rises. Ack falls SYNC_STAGE+1 edges after req falls.
- Incoming req/ack must be glitch-free 4-phase levels. Behaviour on a req that drops before ack is undefined.

## Structure
- Package `gpio_pkg`:
  - `CONF0_W` = 3*PORT_NUM, `CONF1_W` = 2*PORT_NUM+1.
  - `hs_state_t` = {IDLE, REQ, REL}.
- Sub-module `gpio_hs_sync` (SYNC_STAGE flop chain, parameterized width). Instantiated for the din ack, the two conf acks, the dout req, and the ir req vector.
- Master FSM logic is written once as `gpio_hs_master` (parameter DW) and instantiated for din (DW=PORT_NUM) and conf (DW=CONF0_W+CONF1_W; ack = AND of both synced acks).

## Test plan
- **Reset:** hold `reset` 5 cycles mid-REQ (`async_din_req`=1) → all outputs 0 next edge, `wr_ready`=1 after release.
- **din:** write 8'hA5 with a remote that acks 3 cycles after req → `async_din`=A5 stable throughout, req falls SYNC_STAGE+1 edges after ack, `wr_ready` returns, one transaction only.
- **conf:** write cfg_0=24'h003CF0, cfg_1=17'h0AAAA, with conf_1_ack lagging conf_0_ack by 4 cycles → req drops only after both acks are high.
- **dout backpressure:** remote sends 8'h3C then 8'hC3 while `rd_ready`=0 → first captured, second ack withheld. Raise `rd_ready` → 8'h3C popped, then 8'hC3 captured, in order.
- **ir:** pulse req on bits 0 and 8 → `irq_pending`=9'h101, acks complete 4-phase. Assert `irq_clear[0]` in the same cycle a new bit-0 set arrives → bit 0 stays 1.
